weight_kernel_loader: RTL

//  Banked weight store plus a kernel-assembly engine for the PE mesh.
//  - Per request: reads TAPS consecutive words from every bank and shifts them into a staging array.
//  - Hands a full kernel-tap set to the mesh over a valid/ready output port.
//  - Runtime tap count (1..KMAX), one-deep staging so the next fetch overlaps a stalled consumer.
//  - Sits between the DDR weight loader (write side) and the PE array (ker_out).

---
 rtl/weight_kernel_loader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/weight_kernel_loader.sv
// -----------------------------------------------------------------------------
// weight_kernel_loader
//   Banked weight store plus a kernel-assembly engine for the PE mesh.
//   A fetch request reads TAPS consecutive words from every bank. Each word is
//   shifted into a one-deep staging array, and the staging array is committed
//   as a complete kernel onto the ker_out valid/ready port.
//
//   Bank/byte layout: the concatenation of all bank words forms one tap of
//   X_PE*X_MESH bytes. Mesh cell c = i*X_MESH + j is byte (c % (DATA_LEN/8))
//   of bank (c / (DATA_LEN/8)).
//
//   Optional feature macro: WBUF_ZERO_PAD_EN. When it is defined, taps
//   t >= TAPS are forced to zero in ker_out on every commit. Otherwise those
//   taps carry whatever the staging array last held.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   wr_data      WR_LANES write lanes; bank b takes lane b % WR_LANES
//   wr_addr      write address shared by all banks
//   wr_en        per-bank write enable
//   cfg_valid/cfg_ready/cfg_addr/cfg_taps
//                fetch request (first address, tap count; 0 or >KMAX -> KMAX)
//   ker_out      byte (i,j,t) at [t*8 + j*8*KMAX + i*8*KMAX*X_MESH +: 8]
//   ker_taps     valid tap count of ker_out
//   ker_valid/ker_ready
//                kernel output handshake
//   idle         FSM idle and no kernel pending on the output
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and its payload stable until the transfer.
// ready may depend on state but never on valid of the same port.
// -----------------------------------------------------------------------------
module weight_kernel_loader #(
  parameter int X_PE     = 16,
  parameter int X_MESH   = 16,
  parameter int KMAX     = 9,
  parameter int DATA_LEN = 64,
  parameter int ADDR_LEN = 13,
  parameter int WR_LANES = 4,
  localparam int BUFFER_NUM = X_PE * X_MESH * 8 / DATA_LEN,
  localparam int TW         = $clog2(KMAX + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_LEN*WR_LANES-1:0]   wr_data,
  input  logic [ADDR_LEN-1:0]            wr_addr,
  input  logic [BUFFER_NUM-1:0]          wr_en,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [ADDR_LEN-1:0]            cfg_addr,
  input  logic [TW-1:0]                  cfg_taps,
  output logic [X_PE*X_MESH*8*KMAX-1:0]  ker_out,
  output logic [TW-1:0]                  ker_taps,
  output logic                           ker_valid,
  input  logic                           ker_ready,
  output logic                           idle
);

  localparam int CELLS    = X_PE * X_MESH;
  localparam int TAP_BITS = CELLS * 8;
  localparam int KER_BITS = TAP_BITS * KMAX;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_HOLD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_LEN-1:0]   rd_addr_q, rd_addr_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         taps_q, taps_d;
  logic                  rd_vld_q, rd_vld_d;   // bank output holds a requested tap
  logic [TW-1:0]         rd_tap_q, rd_tap_d;   // which tap the bank output holds
  logic [TAP_BITS-1:0]   stage_q [KMAX];
  logic [TAP_BITS-1:0]   stage_d [KMAX];
  logic [KER_BITS-1:0]   ker_out_q, ker_out_d, ker_img;
  logic [TW-1:0]         ker_taps_q, ker_taps_d;
  logic                  ker_valid_q, ker_valid_d;
  logic [TAP_BITS-1:0]   rd_all;
  logic [TW-1:0]         taps_clamped;
  logic                  accept, commit, fetching;

  // ---------------------------------------------------------------------------
  // Weight banks: simple dual-port, registered read. A read that collides
  // with a write to the same address returns the old word.
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < BUFFER_NUM; b++) begin : g_bank
    logic [DATA_LEN-1:0] mem [2**ADDR_LEN];
    logic [DATA_LEN-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (wr_en[b]) mem[wr_addr] <= wr_data[(b % WR_LANES)*DATA_LEN +: DATA_LEN];
      rd_q <= mem[rd_addr_q];
    end
    assign rd_all[b*DATA_LEN +: DATA_LEN] = rd_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cfg_valid) state_d = ST_FETCH;
      ST_FETCH: if (cnt_q == taps_q - TW'(1)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = (!ker_valid_q || ker_ready) ? ST_IDLE : ST_HOLD;
      ST_HOLD:  if (ker_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == ST_IDLE);
    fetching  = (state_q == ST_FETCH);
    // The output register may only be overwritten if it is empty or being
    // drained in this same cycle, so ker_out stays stable while stalled.
    commit    = ((state_q == ST_DRAIN) && (!ker_valid_q || ker_ready)) ||
                ((state_q == ST_HOLD)  && ker_ready);
  end

  assign accept       = cfg_valid && cfg_ready;
  assign taps_clamped = (cfg_taps == '0 || cfg_taps > TW'(KMAX)) ? TW'(KMAX) : cfg_taps;

  // ---------------------------------------------------------------------------
  // Address generation and read tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    taps_d    = taps_q;
    if (accept) begin
      rd_addr_d = cfg_addr;
      cnt_d     = '0;
      taps_d    = taps_clamped;
    end else if (fetching) begin
      rd_addr_d = rd_addr_q + ADDR_LEN'(1);  // wraps mod 2**ADDR_LEN
      cnt_d     = cnt_q + TW'(1);
    end
    rd_vld_d = fetching;
    rd_tap_d = cnt_q;
  end

  // Staging capture. The last tap arrives during DRAIN, so the commit image
  // is built from stage_d and not from stage_q.
  always_comb begin
    for (int t = 0; t < KMAX; t++) begin
      stage_d[t] = stage_q[t];
      if (rd_vld_q && rd_tap_q == TW'(t)) stage_d[t] = rd_all;
    end
  end

  always_comb begin
    ker_img = '0;
    for (int t = 0; t < KMAX; t++) begin
      for (int c = 0; c < CELLS; c++) begin
`ifdef WBUF_ZERO_PAD_EN
        if (TW'(t) < taps_q) ker_img[(c*KMAX + t)*8 +: 8] = stage_d[t][c*8 +: 8];
`else
        ker_img[(c*KMAX + t)*8 +: 8] = stage_d[t][c*8 +: 8];
`endif
      end
    end
  end

  always_comb begin
    ker_out_d  = commit ? ker_img : ker_out_q;
    ker_taps_d = commit ? taps_q  : ker_taps_q;
    if (commit)                        ker_valid_d = 1'b1;
    else if (ker_valid_q && ker_ready) ker_valid_d = 1'b0;
    else                               ker_valid_d = ker_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      taps_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_tap_q    <= '0;
      ker_out_q   <= '0;
      ker_taps_q  <= '0;
      ker_valid_q <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      cnt_q       <= cnt_d;
      taps_q      <= taps_d;
      rd_vld_q    <= rd_vld_d;
      rd_tap_q    <= rd_tap_d;
      ker_out_q   <= ker_out_d;
      ker_taps_q  <= ker_taps_d;
      ker_valid_q <= ker_valid_d;
    end
  end

  // Staging is pure datapath; rd_vld_q gates every capture, so it needs no reset.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign ker_out   = ker_out_q;
  assign ker_taps  = ker_taps_q;
  assign ker_valid = ker_valid_q;
  assign idle      = (state_q == ST_IDLE) && !ker_valid_q;

endmodule
